// File: rtl/spi_frame_rx_if.sv
// rtl/spi_frame_rx_if.sv - SPI pin bundle between the MCU and the frame receiver
interface spi_frame_rx_if;
  logic SCLK;
  logic CS;
  logic MOSI;

  modport master (output SCLK, output CS, output MOSI);
  modport slave  (input SCLK, input CS, input MOSI);
endinterface

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - framed SPI write receiver: header channel byte plus FRAME_BYTES payload
// Optional trailing CRC-8 byte and ERR_CRC output when SPI_CRC8_EN is defined.
module spi_frame_rx #(
  parameter int FRAME_BYTES = 51,
  parameter int N_CH        = 4,
  parameter int CH_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  spi_frame_rx_if.slave            spi,
  output logic [FRAME_BYTES*8-1:0] DATA_OUT,
  output logic [CH_W-1:0]          CH_ID,
  output logic                     WR,
  output logic                     BUSY,
  output logic                     ERR_LEN,
  output logic                     ERR_CH,
`ifdef SPI_CRC8_EN
  output logic                     ERR_CRC,
`endif
  output logic [15:0]              FRAME_CNT
);

`ifdef SPI_CRC8_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int PAY_W = FRAME_BYTES * 8;
  localparam int SR_W  = PAY_W + CRC_BITS;
  localparam int EXP   = 8 + SR_W;
  localparam int CNT_W = $clog2(EXP + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(7);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DONE_WAIT, OVERRUN, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sclk_s, cs_s;
  logic [1:0]       mosi_s;
  logic [SR_W-1:0]  sr, sr_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CH_W-1:0]  pend_ch;
  logic             pend_err;
  logic [7:0]       new_hdr;
  logic             sclk_rise, cs_rise, cs_fall;
  logic             shift, hdr_done, set_len, commit;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign sr_next   = {sr[SR_W-2:0], mosi_s[1]};
  assign new_hdr   = sr_next[7:0];
  assign BUSY      = (state_q != IDLE);

`ifdef SPI_CRC8_EN
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(8 + PAY_W);
  logic [7:0] crc;
  logic [7:0] crc_next;
  // Bit-serial CRC-8 (poly 0x07), MSB first, over header and payload only.
  assign crc_next = (crc[7] ^ mosi_s[1]) ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift    = 1'b0;
    hdr_done = 1'b0;
    set_len  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: ;
      HDR, PAYLOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          set_len = 1'b1;
        end else if (sclk_rise) begin
          shift = 1'b1;
          if (state_q == HDR && bit_cnt == HDR_LAST) begin
            hdr_done = 1'b1;
            state_d  = PAYLOAD;
          end else if (state_q == PAYLOAD && bit_cnt == LAST_BIT) begin
            state_d = DONE_WAIT;
          end
        end
      end
      DONE_WAIT: begin
        if (cs_rise) state_d = COMMIT;
        else if (sclk_rise) state_d = OVERRUN;
      end
      OVERRUN: begin
        if (cs_rise) begin
          state_d = IDLE;
          set_len = 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh CS falling edge always restarts framing, discarding partial data.
    if (cs_fall) state_d = HDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s    <= '0;
      cs_s      <= '0;
      mosi_s    <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      pend_ch   <= '0;
      pend_err  <= 1'b0;
      DATA_OUT  <= '0;
      CH_ID     <= '0;
      WR        <= 1'b0;
      ERR_LEN   <= 1'b0;
      ERR_CH    <= 1'b0;
      FRAME_CNT <= '0;
`ifdef SPI_CRC8_EN
      crc       <= '0;
      ERR_CRC   <= 1'b0;
`endif
    end else begin
      WR <= 1'b0;
      if (clk_en) begin
        sclk_s <= {sclk_s[1:0], spi.SCLK};
        cs_s   <= {cs_s[1:0], spi.CS};
        mosi_s <= {mosi_s[0], spi.MOSI};
        if (cs_fall) begin
          sr       <= '0;
          bit_cnt  <= '0;
          pend_err <= 1'b0;
`ifdef SPI_CRC8_EN
          crc      <= '0;
`endif
        end else if (shift) begin
          sr      <= sr_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef SPI_CRC8_EN
          if (bit_cnt < DATA_BITS) crc <= crc_next;
`endif
          if (hdr_done) begin
            pend_ch  <= new_hdr[CH_W-1:0];
            pend_err <= (int'({24'd0, new_hdr}) >= N_CH);
          end
        end
        if (set_len) ERR_LEN <= 1'b1;
        if (commit) begin
          if (pend_err) begin
            ERR_CH <= 1'b1;
`ifdef SPI_CRC8_EN
          end else if (crc != sr[7:0]) begin
            ERR_CRC <= 1'b1;
`endif
          end else begin
            DATA_OUT  <= sr[SR_W-1 -: PAY_W];
            CH_ID     <= pend_ch;
            WR        <= 1'b1;
            FRAME_CNT <= FRAME_CNT + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed self-checking bench for spi_frame_rx (51-byte frames, 4 channels)
// SPI_CRC8_EN adds the CRC-good and CRC-corrupt frames.
module tb_spi_frame_rx;
  localparam int PAY_W = 408;
`ifdef SPI_CRC8_EN
  localparam int EXP_BITS = 8 + PAY_W + 8;
`else
  localparam int EXP_BITS = 8 + PAY_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic [PAY_W-1:0] data_out;
  logic [3:0]  ch_id;
  logic        wr, busy, err_len, err_ch;
  logic [15:0] frame_cnt;
`ifdef SPI_CRC8_EN
  logic        err_crc;
`endif

  spi_frame_rx_if bus();

  spi_frame_rx #(.FRAME_BYTES(51), .N_CH(4), .CH_W(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .spi(bus),
    .DATA_OUT(data_out), .CH_ID(ch_id), .WR(wr), .BUSY(busy),
    .ERR_LEN(err_len), .ERR_CH(err_ch),
`ifdef SPI_CRC8_EN
    .ERR_CRC(err_crc),
`endif
    .FRAME_CNT(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulses, first;
  logic [PAY_W-1:0] p1, p2;
  logic [527:0] va, vb;

  task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [527:0] build(input logic [7:0] hdr, input logic [PAY_W-1:0] pay);
    logic [527:0] v;
    v = '0;
    v[527 -: 8+PAY_W] = {hdr, pay};
    return v;
  endfunction

`ifdef SPI_CRC8_EN
  function automatic logic [7:0] crc8(input logic [8+PAY_W-1:0] m);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 8 + PAY_W - 1; i >= 0; i--)
      c = (c[7] ^ m[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif

  task automatic cs_low();
    @(negedge clk) bus.CS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [527:0] v, input int from, input int to);
    for (int b = from; b < to; b++) begin
      @(negedge clk) bus.MOSI = v[527-b];
      repeat (3) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (4) @(negedge clk);
      bus.SCLK = 1'b0;
    end
  endtask

  // Raise CS and watch WR for a fixed window; first is the edge count to the pulse.
  task automatic cs_high(output int n, output int f);
    n = 0;
    f = 0;
    @(negedge clk) bus.CS = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (wr === 1'b1) begin
        n++;
        if (f == 0) f = i;
      end
    end
  endtask

  task automatic frame(input logic [527:0] v, input int nbits);
    cs_low();
    send_bits(v, 0, nbits);
    cs_high(pulses, first);
  endtask

  initial begin
    bus.CS = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    p1 = {64'h1, 48'h2800_0000_0000, {11{24'h5AC396}}, 32'h1E0};
    p2 = {{17{24'hF00F81}}, {12{8'h7E}}, 64'hDEAD_BEEF_0123_4567, 32'h8000_0001};
    va = build(8'h02, p1);
    vb = build(8'h03, p2);
`ifdef SPI_CRC8_EN
    va[527-8-PAY_W -: 8] = crc8({8'h02, p1});
    vb[527-8-PAY_W -: 8] = crc8({8'h03, p2});
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_data", data_out, '0);
    chk("rst_ch", ch_id, 4'd0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_err_ch", err_ch, 1'b0);
    chk("rst_cnt", frame_cnt, 16'd0);
`ifdef SPI_CRC8_EN
    chk("rst_err_crc", err_crc, 1'b0);
`endif

    cs_low();
    chk("busy_in_frame", busy, 1'b1);
    send_bits(va, 0, EXP_BITS);
    cs_high(pulses, first);
    chk("good_wr_pulses", pulses, 1);
    chk("good_wr_latency", first, 4);
    chk("good_ch", ch_id, 4'd2);
    chk("good_data", data_out, p1);
    chk("good_cnt", frame_cnt, 16'd1);
    chk("good_err_len", err_len, 1'b0);
    chk("good_err_ch", err_ch, 1'b0);
    chk("good_busy_after", busy, 1'b0);

    frame(vb, 200);
    chk("short_wr", pulses, 0);
    chk("short_err_len", err_len, 1'b1);
    chk("short_data", data_out, p1);
    chk("short_cnt", frame_cnt, 16'd1);

    frame(vb, EXP_BITS + 5);
    chk("overrun_wr", pulses, 0);
    chk("overrun_data", data_out, p1);
    chk("overrun_cnt", frame_cnt, 16'd1);

    frame(build(8'h05, p2), EXP_BITS);
    chk("badch_wr", pulses, 0);
    chk("badch_err_ch", err_ch, 1'b1);
    chk("badch_ch", ch_id, 4'd2);
    chk("badch_data", data_out, p1);

    frame(vb, EXP_BITS);
    chk("ch3_wr", pulses, 1);
    chk("ch3_ch", ch_id, 4'd3);
    chk("ch3_data", data_out, p2);
    chk("ch3_cnt", frame_cnt, 16'd2);

    cs_low();
    send_bits(va, 0, 100);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_data", data_out, '0);
    chk("midrst_ch", ch_id, 4'd0);
    chk("midrst_cnt", frame_cnt, 16'd0);
    chk("midrst_err_len", err_len, 1'b0);
    chk("midrst_err_ch", err_ch, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    send_bits(va, 100, EXP_BITS);
    cs_high(pulses, first);
    chk("stale_frame_wr", pulses, 0);
    chk("stale_frame_err_len", err_len, 1'b0);

    va = build(8'h01, p1);
`ifdef SPI_CRC8_EN
    va[527-8-PAY_W -: 8] = crc8({8'h01, p1});
`endif
    frame(va, EXP_BITS);
    chk("post_rst_wr", pulses, 1);
    chk("post_rst_latency", first, 4);
    chk("post_rst_ch", ch_id, 4'd1);
    chk("post_rst_data", data_out, p1);
    chk("post_rst_cnt", frame_cnt, 16'd1);

    @(negedge clk) clk_en = 1'b0;
    frame(vb, EXP_BITS);
    chk("frozen_wr", pulses, 0);
    chk("frozen_busy", busy, 1'b0);
    @(negedge clk) clk_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("frozen_cnt", frame_cnt, 16'd1);
    chk("frozen_data", data_out, p1);

`ifdef SPI_CRC8_EN
    frame(vb, EXP_BITS);
    chk("crc_good_wr", pulses, 1);
    chk("crc_good_err", err_crc, 1'b0);
    chk("crc_good_cnt", frame_cnt, 16'd2);
    vb[527-8-PAY_W -: 8] = crc8({8'h03, p2}) ^ 8'h01;
    frame(vb, EXP_BITS);
    chk("crc_bad_wr", pulses, 0);
    chk("crc_bad_err", err_crc, 1'b1);
    chk("crc_bad_cnt", frame_cnt, 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Parametrised successor to the fixed 51-byte MCU SPI/DMA receiver.
- Receives one framed SPI write from the MCU: a header byte selecting a target channel, then FRAME_BYTES of payload.
- Oversamples SCLK/CS/MOSI in the FPGA clk domain and checks frame length and channel.
- Publishes the payload with a one-cycle write strobe to the downstream parameter register banks (synthesiser, timing, blanking).

Parameters:
FRAME_BYTES, 51, payload length in bytes (1..64); DATA_OUT width = FRAME_BYTES*8
N_CH, 4, number of addressable channels (1..16)
CH_W, 4, width of CH_ID; N_CH must be <= 2**CH_W

Ports:
clk  in  1  system clock; all logic synchronous to it
rst  in  1  synchronous reset, active-high
clk_en  in  1  clock enable; state, synchronisers and counters advance only when 1
SCLK  in  1  SPI clock from MCU (mode 0, async to clk)
CS  in  1  SPI chip select, active-low (async)
MOSI  in  1  SPI data, MSB first (async)
DATA_OUT  out  FRAME_BYTES*8  last good payload; first received byte in MSBs
CH_ID  out  CH_W  channel of last good frame
WR  out  1  one-clk strobe: DATA_OUT/CH_ID updated this cycle
BUSY  out  1  high while a frame is in progress (synchronised CS low)
ERR_LEN  out  1  sticky: frame ended with bit count != expected
ERR_CH  out  1  sticky: header channel >= N_CH
FRAME_CNT  out  16  count of good frames, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state IDLE, shift register and bit counter 0.
- Input sync: SCLK, CS and MOSI each pass through 2 FFs; a third FF provides edge detect. Legal SCLK <= f(clk, enabled)/4.
- MOSI is sampled on a synchronised SCLK rising edge. Bits shift into the LSB, so the register shifts left.
- Expected bit total: EXP = 8 + FRAME_BYTES*8, plus 8 when SPI_CRC8_EN is defined.
- FSM:
  - IDLE: on CS falling edge (sync) clear bit counter -> HDR. BUSY = 1 in every state except IDLE.
  - HDR: after 8 bits, latch header[CH_W-1:0] into a pending channel -> PAYLOAD. If header >= N_CH, set pending-error flag and still -> PAYLOAD.
  - PAYLOAD: count bits. On bit count == EXP, stop shifting -> DONE_WAIT. On CS rising edge before EXP -> IDLE and set ERR_LEN.
  - DONE_WAIT: further SCLK edges -> OVERRUN. On CS rising edge -> COMMIT.
  - OVERRUN: ignore data; on CS rising edge -> IDLE and set ERR_LEN (no commit).
  - COMMIT (1 clk):
    - If no channel error (and, with CRC, the CRC matches): DATA_OUT <= payload, CH_ID <= pending, WR = 1, FRAME_CNT += 1.
    - On channel error: set ERR_CH and do not commit.
    - Always -> IDLE.
- WR latency: WR high exactly 4 enabled clk edges after CS rises at the pin, when the frame is good.
- DATA_OUT and CH_ID hold their value between commits; a bad frame never alters them.
- ERR_LEN and ERR_CH are sticky; cleared only by rst.
- CS falling edge in any non-IDLE state (glitch, new frame without release): restart at HDR and discard partial data; no error is flagged.
- rst mid-frame: immediate return to IDLE, all outputs 0. The frame in flight is lost. A frame whose CS is already low at reset release is ignored until the next CS falling edge.
- clk_en = 0: everything frozen, including the synchronisers; WR never asserted.

Optional Feature:
- Macro SPI_CRC8_EN.
- Defined:
  - The frame carries one trailing CRC byte: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over header + payload.
  - The CRC is computed bit-serially as bits arrive.
  - Extra sticky output ERR_CRC (1 bit, reset 0). On CRC mismatch the frame is not committed and ERR_CRC is set.
- Undefined: no CRC byte; EXP excludes it; the ERR_CRC port is absent.

Test Plan:
- FRAME_BYTES=51, header 0x02, payload {64'h1, 48'h280000000000, ..., 32'h1E0} -> WR pulse 1 clk, CH_ID=2, DATA_OUT equals payload, FRAME_CNT=1, no errors.
- CS released after 200 bits -> no WR, ERR_LEN=1, DATA_OUT unchanged from the previous frame.
- 8+408+5 bits then CS high -> OVERRUN path, ERR_LEN=1, no WR.
- Header 0x05 with N_CH=4 -> ERR_CH=1, no WR, CH_ID unchanged.
- rst pulsed at bit 100, then a full good frame with header 0x01 -> outputs 0 after reset; the second frame commits, FRAME_CNT=1.
- SPI_CRC8_EN: good frame with correct CRC -> WR; same frame with CRC byte XOR 0x01 -> ERR_CRC=1, no WR.
